life_board: RTL

Parametrised Game-of-Life board: a ROWS×COLS array of rule-programmable cells with row-wise load, single-step and free-run control, a generation counter and still-life detection. It generalises the single fixed-rule cell to a full board with runtime-selectable Life-like rules (B/S masks) and optional toroidal edges. It sits between the host or UART loader and the display scanner, which reads `cells_q`.

---
 rtl/life_pkg.sv | 25 ++
 rtl/life_rule_cell.sv | 31 +++
 rtl/life_board.sv | 121 ++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types, default Conway masks and the neighbour popcount helper
// for the life_board Game-of-Life array.
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;
  localparam int         NCOUNT_W       = 4;

  // Counts live neighbours; result 0..8 indexes the 9-bit rule masks.
  function automatic logic [NCOUNT_W-1:0] popcount8(input logic [7:0] v);
    logic [NCOUNT_W-1:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/life_rule_cell.sv
// Combinational next-state of one Life-like cell: popcount of its eight
// neighbours looked up in the birth or survive mask.
module life_rule_cell
  import life_pkg::*;
(
  input  logic       alive_i,
  input  logic [7:0] nbr_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  logic [NCOUNT_W-1:0] count_s;

  assign count_s = popcount8(nbr_i);

  // Select the mask by current liveness, then index it by neighbour count.
  always_comb begin
    next_o = 1'b0;
    if (count_s <= 4'd8) begin
      if (alive_i) begin
        next_o = survive_mask_i[count_s];
      end else begin
        next_o = birth_mask_i[count_s];
      end
    end else begin
      next_o = 1'b0;
    end
  end

endmodule

// File: rtl/life_board.sv
// ROWS x COLS rule-programmable Life board with row load, step/run control,
// generation counter and still-life detection. LIFE_BOARD_TORUS_EN wraps edges.
module life_board
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [8:0]              birth_mask,
  input  logic [8:0]              survive_mask,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [$clog2(ROWS)-1:0] load_row,
  input  logic [COLS-1:0]         load_data,
  input  logic                    step,
  input  logic                    run,
  output logic [ROWS*COLS-1:0]    cells_q,
  output logic [GEN_W-1:0]        generation,
  output logic                    stable
);

  state_t                 state_q;
  logic [GEN_W-1:0]       gen_q;
  logic [GEN_W-1:0]       gen_d;
  logic                   stable_q;
  logic [ROWS*COLS-1:0]   cells_d;
  logic                   same_s;

  // Neighbour lookup; off-board positions wrap or read as dead.
  function automatic logic cell_at(input logic [ROWS*COLS-1:0] b,
                                   input int r, input int c);
`ifdef LIFE_BOARD_TORUS_EN
    int rr;
    int cc;
    rr = (r + ROWS) % ROWS;
    cc = (c + COLS) % COLS;
    return b[rr*COLS + cc];
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
      return 1'b0;
    end else begin
      return b[r*COLS + c];
    end
`endif
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr_s;
      assign nbr_s = {cell_at(cells_q, r-1, c-1), cell_at(cells_q, r-1, c),
                      cell_at(cells_q, r-1, c+1), cell_at(cells_q, r,   c-1),
                      cell_at(cells_q, r,   c+1), cell_at(cells_q, r+1, c-1),
                      cell_at(cells_q, r+1, c),   cell_at(cells_q, r+1, c+1)};
      life_rule_cell u_cell (
        .alive_i        (cells_q[r*COLS + c]),
        .nbr_i          (nbr_s),
        .birth_mask_i   (birth_mask),
        .survive_mask_i (survive_mask),
        .next_o         (cells_d[r*COLS + c])
      );
    end
  end

  assign same_s     = (cells_d == cells_q);
  assign gen_d      = gen_q + {{(GEN_W-1){1'b0}}, 1'b1};
  assign load_ready = !rst && ena && (state_q == S_IDLE);
  assign generation = gen_q;
  assign stable     = stable_q;

  // Control FSM with board, generation and stability registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cells_q  <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (load_valid && load_ready) begin
            // Out-of-range rows still complete the handshake but write nothing.
            if (int'(load_row) < ROWS) begin
              cells_q[int'(load_row)*COLS +: COLS] <= load_data;
            end
            gen_q    <= '0;
            stable_q <= 1'b0;
          end else if (run) begin
            state_q <= S_RUN;
          end else if (step) begin
            cells_q  <= cells_d;
            gen_q    <= gen_d;
            stable_q <= same_s;
          end
        end
        S_RUN: begin
          cells_q  <= cells_d;
          gen_q    <= gen_d;
          stable_q <= same_s;
          if (!run) begin
            state_q <= S_IDLE;
          end else if (same_s) begin
            state_q <= S_HALT;
          end
        end
        S_HALT: begin
          if (!run) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
